// File: rtl/es_dsc_pkg.sv
// Shared types and sizing helpers for the dot-product operand sequencer.
// The run-counter width and timeout limit derive from the operand geometry.
package es_dsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_OUT  = 3'd4
    } dsc_state_e;

    localparam int DEF_NUM_INPUTS = 2;
    localparam int DEF_DATA_WIDTH = 5;

    function automatic int run_width(input int n, input int w);
        return n * w + 2;
    endfunction

    // Cycles allowed in RUN before a product is declared stuck.
    function automatic int tmo_limit(input int n, input int w);
        return (1 << (n * w)) + 2;
    endfunction

    localparam int RUN_W = run_width(DEF_NUM_INPUTS, DEF_DATA_WIDTH);

endpackage

// File: rtl/es_bs_dot_seq_acc.sv
// Wrapping accumulator with sticky wrap/error flags and a saturating term count.
// The sum is modulo 2^ACC_WIDTH; any carry out of the top bit marks overflow.
module es_sat_acc
    import es_dsc_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int TERM_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 add_i,
    input  logic [TERM_W-1:0]    term_i,
    input  logic                 err_set_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o,
    output logic                 err_o
);

    localparam int SW = ((ACC_WIDTH > TERM_W) ? ACC_WIDTH : TERM_W) + 1;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic [SW-1:0]        sum_full;

    assign sum_full = SW'(acc_q) + SW'(term_i);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        err_d = err_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            err_d = 1'b0;
        end else if (add_i) begin
            acc_d = sum_full[ACC_WIDTH-1:0];
            ovf_d = ovf_q | (|sum_full[SW-1:ACC_WIDTH]);
            err_d = err_q | err_set_i;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign sum_o = acc_q;
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
    assign err_o = err_q;

endmodule

// File: rtl/es_bs_dot_seq.sv
// Operand sequencer around an external bit-serial multiplier: loads one tuple,
// clears and runs the multiplier, accumulates products, emits the dot product.
module es_bs_dot_seq
    import es_dsc_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = 11,
    parameter int ACC_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_INPUTS],
    input  logic                  in_last,
    output logic                  mul_clr,
    output logic                  mul_en,
    output logic [DATA_WIDTH-1:0] mul_data [NUM_INPUTS],
    input  logic [WXIP1-1:0]      mul_result,
    input  logic                  mul_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf,
    output logic                  out_err
);

    localparam int RunW = run_width(NUM_INPUTS, DATA_WIDTH);
    localparam int TmoLim = tmo_limit(NUM_INPUTS, DATA_WIDTH);
    localparam logic [RunW-1:0] RUN_LAST = RunW'(TmoLim - 1);

    dsc_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] mul_data_q [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] mul_data_d [NUM_INPUTS];
    logic                  last_q, last_d;
    logic [RunW-1:0]       run_cnt_q, run_cnt_d;
    logic                  tmo_q, tmo_d;
    logic                  acc_add, acc_clr;

    always_comb begin
        state_d    = state_q;
        mul_data_d = mul_data_q;
        last_d     = last_q;
        run_cnt_d  = run_cnt_q;
        tmo_d      = tmo_q;
        in_ready   = 1'b0;
        mul_clr    = 1'b0;
        mul_en     = 1'b0;
        out_valid  = 1'b0;
        acc_add    = 1'b0;
        acc_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mul_data_d = in_data;
                    last_d     = in_last;
                    state_d    = ST_CLR;
                end
            end
            ST_CLR: begin
                mul_clr   = 1'b1;
                run_cnt_d = '0;
                tmo_d     = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                mul_en    = 1'b1;
                run_cnt_d = run_cnt_q + 1'b1;
                // First RUN cycle ignores done: the multiplier is just out of clear.
                if ((run_cnt_q != '0) && mul_done) begin
                    state_d = ST_CAPT;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d = ST_CAPT;
                    tmo_d   = 1'b1;
                end
            end
            ST_CAPT: begin
                acc_add = 1'b1;
                state_d = last_q ? ST_OUT : ST_IDLE;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b0;
            run_cnt_q <= '0;
            tmo_q     <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                mul_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            run_cnt_q  <= run_cnt_d;
            tmo_q      <= tmo_d;
            mul_data_q <= mul_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_mul_data
            assign mul_data[gi] = mul_data_q[gi];
        end
    endgenerate

    es_sat_acc #(
        .ACC_WIDTH (ACC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .TERM_W    (WXIP1)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (acc_clr),
        .add_i     (acc_add),
        .term_i    (mul_result),
        .err_set_i (tmo_q),
        .sum_o     (out_sum),
        .cnt_o     (out_count),
        .ovf_o     (out_ovf),
        .err_o     (out_err)
    );

endmodule

// File: tb/tb_es_bs_dot_seq.sv
// Directed bench for es_bs_dot_seq: two instances (16- and 11-bit accumulators),
// each driving a behavioural bit-serial multiplier model.
module tb_es_bs_dot_seq;

    localparam int DW  = 5;
    localparam int NI  = 2;
    localparam int WX  = 11;
    localparam int CW  = 8;
    localparam int AWA = 16;
    localparam int AWB = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic [DW-1:0] in_data [NI];
    logic          in_last, out_ready;
    logic          mclr [2];
    logic          men [2];
    logic          mdone [2];
    logic [WX-1:0] mres [2];
    logic [2*DW-1:0] mprod [2];
    logic [DW-1:0] mul_data_a [NI];
    logic [DW-1:0] mul_data_b [NI];
    logic          out_valid_a, out_valid_b;
    logic [AWA-1:0] out_sum_a;
    logic [AWB-1:0] out_sum_b;
    logic [CW-1:0] out_count_a, out_count_b;
    logic          out_ovf_a, out_ovf_b, out_err_a, out_err_b;
    logic          stuck;
    int            compared, mismatched;

    es_bs_dot_seq #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX), .ACC_WIDTH(AWA), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .in_last(in_last), .mul_clr(mclr[0]), .mul_en(men[0]), .mul_data(mul_data_a),
        .mul_result(mres[0]), .mul_done(mdone[0]), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_count(out_count_a), .out_ovf(out_ovf_a), .out_err(out_err_a)
    );

    es_bs_dot_seq #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX), .ACC_WIDTH(AWB), .CNT_WIDTH(CW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .in_last(in_last), .mul_clr(mclr[1]), .mul_en(men[1]), .mul_data(mul_data_b),
        .mul_result(mres[1]), .mul_done(mdone[1]), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b), .out_err(out_err_b)
    );

    assign mprod[0] = (2*DW)'(mul_data_a[0]) * (2*DW)'(mul_data_a[1]);
    assign mprod[1] = (2*DW)'(mul_data_b[0]) * (2*DW)'(mul_data_b[1]);

    // Multiplier model: counts one step per enabled cycle up to the product, then holds done.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mul
            logic [WX-1:0] cnt_q, res_q;
            logic          done_q;
            always @(posedge clk) begin
                if (rst || mclr[gi]) begin
                    cnt_q <= '0; res_q <= '0; done_q <= 1'b0;
                end else if (men[gi] && !done_q) begin
                    if (cnt_q >= {1'b0, mprod[gi]}) begin
                        done_q <= 1'b1; res_q <= {1'b0, mprod[gi]};
                    end else begin
                        cnt_q <= cnt_q + 1'b1; res_q <= cnt_q + 1'b1;
                    end
                end
            end
            assign mres[gi]  = res_q;
            assign mdone[gi] = done_q & ~(stuck & (gi == 0));
        end
    endgenerate

    // Monitor of instance A multiplier control.
    logic mon_clear, clr_prev, clr_long;
    int   clr_pulses, en_cycles;
    always @(posedge clk) begin
        if (mon_clear) begin
            clr_pulses <= 0; en_cycles <= 0; clr_long <= 1'b0; clr_prev <= 1'b0;
        end else begin
            if (mclr[0] && !clr_prev) clr_pulses <= clr_pulses + 1;
            if (mclr[0] && clr_prev) clr_long <= 1'b1;
            clr_prev <= mclr[0];
            if (men[0]) en_cycles <= en_cycles + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int inst, input int a, input int b, input bit l);
        int n;
        bit rdy, done;
        in_data[0] = DW'(a);
        in_data[1] = DW'(b);
        in_last = l;
        if (inst == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done) begin
            rdy = (inst == 0) ? in_ready_a : in_ready_b;
            tick();
            n++;
            if (rdy) begin
                done = 1'b1;
                $display("tuple inst=%0d (%0d,%0d) last=%0d accepted", inst, a, b, l);
            end else if (n > 5000) begin
                compared++; mismatched++;
                $display("FAIL send_timeout inst=%0d: in_ready never seen, required 1", inst);
                done = 1'b1;
            end
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_out(input int inst, input int budget, output int cycles);
        cycles = 0;
        while (!((inst == 0) ? out_valid_a : out_valid_b) && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!((inst == 0) ? out_valid_a : out_valid_b)) begin
            compared++; mismatched++;
            $display("FAIL out_timeout inst=%0d: out_valid=0 after %0d cycles, required 1", inst, cycles);
        end else begin
            $display("sum inst=%0d valid after %0d cycles", inst, cycles);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        compared++; if (in_ready_a !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready: got %0b required 1", in_ready_a); end
        compared++; if (mclr[0] !== 1'b0 || men[0] !== 1'b0) begin mismatched++; $display("FAIL rst_mul_ctl: got clr=%0b en=%0b required 0/0", mclr[0], men[0]); end
        compared++; if (out_valid_a !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %0b required 0", out_valid_a); end
        compared++; if (out_sum_a !== 16'd0 || out_count_a !== 8'd0) begin mismatched++; $display("FAIL rst_sum: got sum=%0d cnt=%0d required 0/0", out_sum_a, out_count_a); end
        compared++; if (mul_data_a[0] !== 5'd0 || mul_data_a[1] !== 5'd0) begin mismatched++; $display("FAIL rst_mul_data: got %0d,%0d required 0,0", mul_data_a[0], mul_data_a[1]); end
        $display("reset done");
    endtask

    task automatic test_single();
        int cyc;
        send(0, 31, 31, 1'b1);
        wait_out(0, 2000, cyc);
        compared++; if (out_sum_a !== 16'd961) begin mismatched++; $display("FAIL single_sum: got %0d required 961", out_sum_a); end
        compared++; if (out_count_a !== 8'd1) begin mismatched++; $display("FAIL single_count: got %0d required 1", out_count_a); end
        compared++; if (out_ovf_a !== 1'b0 || out_err_a !== 1'b0) begin mismatched++; $display("FAIL single_flags: got ovf=%0b err=%0b required 0/0", out_ovf_a, out_err_a); end
        handshake();
        compared++; if (out_valid_a !== 1'b0 || out_sum_a !== 16'd0) begin mismatched++; $display("FAIL single_clear: got valid=%0b sum=%0d required 0/0", out_valid_a, out_sum_a); end
    endtask

    task automatic test_dot();
        int cyc;
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        send(0, 3, 4, 1'b0);
        compared++; if (mul_data_a[0] !== 5'd3 || mul_data_a[1] !== 5'd4) begin mismatched++; $display("FAIL dot_load: got %0d,%0d required 3,4", mul_data_a[0], mul_data_a[1]); end
        compared++; if (in_ready_a !== 1'b0) begin mismatched++; $display("FAIL dot_busy: got in_ready=%0b required 0", in_ready_a); end
        in_data[0] = 5'd5; in_data[1] = 5'd6; in_valid_a = 1'b1;
        tick(); tick();
        compared++; if (mul_data_a[0] !== 5'd3 || mul_data_a[1] !== 5'd4) begin mismatched++; $display("FAIL dot_hold: got %0d,%0d required 3,4", mul_data_a[0], mul_data_a[1]); end
        send(0, 5, 6, 1'b0);
        send(0, 7, 2, 1'b1);
        wait_out(0, 500, cyc);
        compared++; if (out_sum_a !== 16'd56) begin mismatched++; $display("FAIL dot_sum: got %0d required 56", out_sum_a); end
        compared++; if (out_count_a !== 8'd3) begin mismatched++; $display("FAIL dot_count: got %0d required 3", out_count_a); end
        compared++; if (clr_pulses !== 3 || clr_long !== 1'b0) begin mismatched++; $display("FAIL dot_clr_pulses: got %0d long=%0b required 3 long=0", clr_pulses, clr_long); end
        handshake();
    endtask

    task automatic test_zero();
        int cyc;
        send(0, 0, 7, 1'b1);
        wait_out(0, 50, cyc);
        compared++; if (cyc > 4) begin mismatched++; $display("FAIL zero_latency: got %0d cycles required <=4", cyc); end
        compared++; if (out_sum_a !== 16'd0 || out_count_a !== 8'd1) begin mismatched++; $display("FAIL zero_sum: got sum=%0d cnt=%0d required 0/1", out_sum_a, out_count_a); end
        compared++; if (out_err_a !== 1'b0) begin mismatched++; $display("FAIL zero_err: got %0b required 0", out_err_a); end
        handshake();
    endtask

    task automatic test_backpressure();
        int cyc;
        send(0, 2, 3, 1'b1);
        wait_out(0, 50, cyc);
        in_data[0] = 5'd1; in_data[1] = 5'd1; in_last = 1'b1; in_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (out_valid_a !== 1'b1 || out_sum_a !== 16'd6 || out_count_a !== 8'd1 || in_ready_a !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: got valid=%0b sum=%0d cnt=%0d rdy=%0b required 1/6/1/0", i, out_valid_a, out_sum_a, out_count_a, in_ready_a);
            end
            tick();
        end
        handshake();
        compared++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin mismatched++; $display("FAIL bp_release: got valid=%0b rdy=%0b required 0/1", out_valid_a, in_ready_a); end
        tick();
        in_valid_a = 1'b0;
        $display("tuple inst=0 (1,1) last=1 accepted");
        compared++; if (in_ready_a !== 1'b0 || mul_data_a[0] !== 5'd1) begin mismatched++; $display("FAIL bp_accept: got rdy=%0b data0=%0d required 0/1", in_ready_a, mul_data_a[0]); end
        wait_out(0, 50, cyc);
        compared++; if (out_sum_a !== 16'd1) begin mismatched++; $display("FAIL bp_next_sum: got %0d required 1", out_sum_a); end
        handshake();
    endtask

    task automatic test_ovf();
        int cyc;
        send(1, 31, 31, 1'b0);
        send(1, 31, 31, 1'b0);
        send(1, 31, 31, 1'b1);
        wait_out(1, 3000, cyc);
        compared++; if (out_sum_b !== 11'd835) begin mismatched++; $display("FAIL ovf_sum: got %0d required 835", out_sum_b); end
        compared++; if (out_ovf_b !== 1'b1 || out_count_b !== 8'd3) begin mismatched++; $display("FAIL ovf_flag: got ovf=%0b cnt=%0d required 1/3", out_ovf_b, out_count_b); end
        handshake();
        send(1, 1, 1, 1'b1);
        wait_out(1, 50, cyc);
        compared++; if (out_sum_b !== 11'd1 || out_ovf_b !== 1'b0) begin mismatched++; $display("FAIL ovf_next: got sum=%0d ovf=%0b required 1/0", out_sum_b, out_ovf_b); end
        handshake();
    endtask

    task automatic test_rst_timeout();
        int cyc;
        send(0, 31, 31, 1'b1);
        repeat (10) tick();
        compared++; if (men[0] !== 1'b1) begin mismatched++; $display("FAIL rt_running: got mul_en=%0b required 1", men[0]); end
        rst = 1'b1; tick(); rst = 1'b0;
        compared++; if (out_sum_a !== 16'd0 || out_count_a !== 8'd0 || out_ovf_a !== 1'b0 || out_err_a !== 1'b0 || out_valid_a !== 1'b0) begin
            mismatched++; $display("FAIL rt_outputs: got sum=%0d cnt=%0d ovf=%0b err=%0b valid=%0b required all 0", out_sum_a, out_count_a, out_ovf_a, out_err_a, out_valid_a);
        end
        compared++; if (in_ready_a !== 1'b1 || men[0] !== 1'b0 || mclr[0] !== 1'b0) begin mismatched++; $display("FAIL rt_idle: got rdy=%0b en=%0b clr=%0b required 1/0/0", in_ready_a, men[0], mclr[0]); end
        stuck = 1'b1;
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        send(0, 3, 3, 1'b1);
        wait_out(0, 2000, cyc);
        compared++; if (en_cycles !== 1026) begin mismatched++; $display("FAIL rt_run_cycles: got %0d required 1026", en_cycles); end
        compared++; if (out_err_a !== 1'b1) begin mismatched++; $display("FAIL rt_err: got %0b required 1", out_err_a); end
        compared++; if (out_sum_a !== 16'd9 || out_count_a !== 8'd1) begin mismatched++; $display("FAIL rt_sum: got sum=%0d cnt=%0d required 9/1", out_sum_a, out_count_a); end
        handshake();
        compared++; if (out_err_a !== 1'b0) begin mismatched++; $display("FAIL rt_err_clear: got %0b required 0", out_err_a); end
        stuck = 1'b0;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_data[0] = '0; in_data[1] = '0; stuck = 1'b0; mon_clear = 1'b1;
        test_reset();
        mon_clear = 1'b0;
        test_single();
        test_dot();
        test_zero();
        test_backpressure();
        test_ovf();
        test_rst_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/es_bs_dot_seq.md
Name: es_bs_dot_seq

Overview:
- Operand sequencer and result accumulator that sits directly upstream and downstream of es_ordered_bs_mul.
- Accepts operand tuples over a valid/ready stream and loads each tuple into the multiplier.
- Clears and enables the multiplier, waits for its done, then captures the product count.
- Accumulates products until a tuple tagged last arrives, then presents the dot-product sum on a valid/ready output.

Parameters:
- DATA_WIDTH, 5: bit width of each operand.
- NUM_INPUTS, 2: operands per tuple (2..5).
- WXIP1, 11: multiplier product-count width (NUM_INPUTS*DATA_WIDTH+1).
- ACC_WIDTH, 16: accumulator width.
- CNT_WIDTH, 8: width of the product counter per dot product.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand tuple valid
- in_ready  out  1  sequencer can accept a tuple
- in_data  in  [DATA_WIDTH-1:0] x NUM_INPUTS (unpacked)  operand tuple
- in_last  in  1  tuple is the final term of the dot product
- mul_clr  out  1  synchronous clear pulse to the multiplier rst
- mul_en  out  1  multiplier enable
- mul_data  out  [DATA_WIDTH-1:0] x NUM_INPUTS  registered operands to the multiplier bin_data_in
- mul_result  in  WXIP1  multiplier bin_data_out
- mul_done  in  1  multiplier done
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- out_sum  out  ACC_WIDTH  accumulated dot product
- out_count  out  CNT_WIDTH  number of products in out_sum
- out_ovf  out  1  sticky: accumulator wrapped during this dot product
- out_err  out  1  sticky: a product hit the timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all registers 0; FSM in IDLE; in_ready=1; mul_clr=0; mul_en=0; out_valid=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_data into mul_data and in_last into last_q, then go to CLR.
  - CLR: mul_clr=1 for exactly 1 cycle, mul_en=0, then go to RUN.
  - RUN: mul_en=1. mul_done is ignored in the first RUN cycle (mask cycle). From the second cycle on, mul_done=1 sends the FSM to CAPT.
  - CAPT: mul_en=0. acc <= acc + mul_result (zero-extended), with modulo 2^ACC_WIDTH wrap. Wrap sets ovf. cnt <= cnt+1, saturating at all-ones. If last_q, go to OUT; else go to IDLE.
  - OUT: out_valid=1 with out_sum/out_count/out_ovf/out_err stable. On out_ready, clear acc, cnt, ovf and err, then go to IDLE.
- in_ready=1 only in IDLE, so at most one tuple is in flight. Tuples presented in other states are stalled.
- mul_data changes only in the IDLE accept cycle and is held through CLR/RUN/CAPT.
- Timeout: a run counter of width NUM_INPUTS*DATA_WIDTH+2 clears on entry to RUN. If it reaches 2^(NUM_INPUTS*DATA_WIDTH)+2 without an unmasked mul_done, the FSM forces CAPT (capturing the current mul_result) and sets err.
- Latency: per tuple, accept + 1 (CLR) + run cycles + 1 (CAPT). The first out_valid occurs in the cycle after CAPT of the last tuple.
- Simultaneous events:
  - out_ready asserted in the same cycle out_valid first rises: the handshake completes that cycle.
  - rst asserted in any state overrides everything; in-flight products and the partial sum are discarded.
- A tuple with an operand of 0 completes normally with product 0.

Decomposition:
- Shared package es_dsc_pkg holds:
  - state enum {IDLE, CLR, RUN, CAPT, OUT}
  - a function for the timeout limit from NUM_INPUTS and DATA_WIDTH
  - localparam RUN_W
- One natural sub-module: es_sat_acc (wrapping adder with sticky overflow and saturating term counter).
- The multiplier is instantiated by the bench/top, not inside this block.

Test Plan:
- Single tuple (31,31) with last=1, driving a real es_ordered_bs_mul (N=2, W=5) -> out_sum=961, out_count=1, out_ovf=0, out_err=0.
- Dot product (3,4),(5,6),(7,2) with last on the third tuple -> out_sum=56, out_count=3; mul_clr pulses exactly 3 times, each 1 cycle.
- Zero operand (0,7), last -> out_sum=0; completion within 4 cycles of accept; no timeout.
- ACC_WIDTH=11, three tuples (31,31) -> out_sum=835 (2883 mod 2048), out_ovf=1. The next dot product (1,1) -> out_sum=1, out_ovf=0.
- Backpressure: out_ready low for 5 cycles after out_valid -> outputs held stable and in_ready=0 throughout; accept resumes the cycle after the handshake.
- rst pulsed mid-RUN, then a stuck-low mul_done stub -> after reset, all outputs are 0 and the FSM is in IDLE; with the stub, err sets after 1026 RUN cycles and out_err=1 at OUT.
